// File: rtl/servo_motion_scheduler.sv
// Gesture scheduler for a five-finger servo hand: queues gesture codes, ramps
// every finger pulse width toward its decoded target once per motion tick, then dwells.
module servo_motion_scheduler #(
  parameter int TICK_CYCLES = 50000,
  parameter int STEP_US     = 20,
  parameter int HOLD_TICKS  = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_gesture,
  output logic        cmd_ready,
  output logic [79:0] widths,
  output logic        busy,
  output logic        done_pulse,
  output logic        err_pulse
);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [15:0]   STEP      = 16'(STEP_US);
  localparam logic [15:0]   W_CENTER  = 16'd1500;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RAMP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_fifo [4];
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic [2:0]    r_count;
  logic [TW-1:0] r_tick_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [7:0]    r_gesture;
  logic [15:0]   r_width  [5];
  logic [15:0]   r_target [5];
  logic          r_done;
  logic          r_err;

  logic w_push, w_pop, w_tick, w_at_target, w_known;
  logic w_load, w_err, w_done, w_step, w_hold_clr, w_hold_inc;

  // Difference is always taken larger-minus-smaller so the unsigned math never wraps.
  function automatic logic [15:0] f_step(input logic [15:0] cur, input logic [15:0] tgt);
    logic [15:0] diff;
    if (cur < tgt) begin
      diff   = tgt - cur;
      f_step = cur + ((diff > STEP) ? STEP : diff);
    end else begin
      diff   = cur - tgt;
      f_step = cur - ((diff > STEP) ? STEP : diff);
    end
  endfunction

  function automatic logic [15:0] f_target(input logic [7:0] code, input int finger);
    if (code == 8'h10) begin
      f_target = 16'd1000;
    end else if (code == 8'h11) begin
      f_target = 16'd2000;
    end else if (finger == 1) begin
      f_target = 16'd1000 + 16'd100 * {8'd0, code - 8'd1};
    end else begin
      f_target = W_CENTER;
    end
  endfunction

  assign cmd_ready  = ~reset & (r_count != 3'd4);
  assign w_push     = cmd_valid & cmd_ready;
  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_known    = ((r_gesture >= 8'h01) && (r_gesture <= 8'h0B)) ||
                      (r_gesture == 8'h10) || (r_gesture == 8'h11);
  assign busy       = (r_count != 3'd0) || (r_state != S_IDLE);
  assign done_pulse = r_done;
  assign err_pulse  = r_err;
  assign widths     = {r_width[4], r_width[3], r_width[2], r_width[1], r_width[0]};

  always_comb begin
    w_at_target = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_at_target = w_at_target & (r_width[i] == r_target[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= cmd_gesture;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Motion tick runs regardless of state so tick phase never depends on command timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_err       = 1'b0;
    w_done      = 1'b0;
    w_step      = 1'b0;
    w_hold_clr  = 1'b0;
    w_hold_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != 3'd0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_known) begin
          w_load      = 1'b1;
          w_state_nxt = S_RAMP;
        end else if (r_gesture == 8'h00) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      // Arrival is tested before stepping, so a gesture already satisfied skips the ramp.
      S_RAMP: begin
        if (w_at_target) begin
          w_hold_clr  = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_step = w_tick;
        end
      end
      S_HOLD: begin
        if (w_tick && (r_hold_cnt == HOLD_LAST)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_inc = w_tick;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gesture  <= 8'h00;
      r_hold_cnt <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        r_width[i]  <= W_CENTER;
        r_target[i] <= W_CENTER;
      end
    end else begin
      r_done <= w_done;
      r_err  <= w_err;
      if (w_pop) r_gesture <= r_fifo[r_rd_ptr];
      if (w_hold_clr) begin
        r_hold_cnt <= '0;
      end else if (w_hold_inc) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
      for (int i = 0; i < 5; i++) begin
        if (w_load) r_target[i] <= f_target(r_gesture, i);
        if (w_step) r_width[i]  <= f_step(r_width[i], r_target[i]);
      end
    end
  end
endmodule

// File: tb/tb_servo_motion_scheduler.sv
// Directed bench for servo_motion_scheduler: a queue-based gesture model is compared
// every cycle, and literal expectations pin the key sequences.
module tb_servo_motion_scheduler;
  localparam int TICK = 4;
  localparam int STEP = 100;
  localparam int HOLD = 2;

  logic        clk, reset;
  logic        cmd_valid, c3_valid;
  logic [7:0]  cmd_gesture, c3_gesture;
  logic        cmd_ready, c3_ready;
  logic [79:0] widths, c3_widths;
  logic        busy, c3_busy, done_pulse, c3_done, err_pulse, c3_err;

  servo_motion_scheduler #(.TICK_CYCLES(TICK), .STEP_US(STEP), .HOLD_TICKS(HOLD)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_gesture(cmd_gesture),
    .cmd_ready(cmd_ready), .widths(widths), .busy(busy),
    .done_pulse(done_pulse), .err_pulse(err_pulse));

  servo_motion_scheduler #(.TICK_CYCLES(TICK), .STEP_US(300), .HOLD_TICKS(HOLD)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(c3_valid), .cmd_gesture(c3_gesture),
    .cmd_ready(c3_ready), .widths(c3_widths), .busy(c3_busy),
    .done_pulse(c3_done), .err_pulse(c3_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Gesture model: a queue of codes plus the current phase of the active gesture.
  int         m_w [5];
  int         m_t [5];
  logic [7:0] m_q [$];
  int         m_mode;   // 0 idle, 1 decoding, 2 moving, 3 dwelling
  int         m_cur;
  int         m_phase;
  int         m_hold;
  bit         m_done, m_err;

  function automatic logic [79:0] exp_widths();
    logic [79:0] v;
    for (int i = 0; i < 5; i++) v[16*i +: 16] = 16'(m_w[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_w[i] = 1500;
      m_t[i] = 1500;
    end
    m_q.delete();
    m_mode = 0; m_cur = 0; m_phase = 0; m_hold = 0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit tick, can_push, arrived;
    int d;
    tick     = (m_phase == TICK - 1);
    m_phase  = tick ? 0 : m_phase + 1;
    can_push = cmd_valid && (m_q.size() < 4);
    m_done   = 1'b0;
    m_err    = 1'b0;
    if (m_mode == 0) begin
      if (m_q.size() > 0) begin
        m_cur  = int'(m_q.pop_front());
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (m_cur >= 1 && m_cur <= 11) begin
        for (int i = 0; i < 5; i++) m_t[i] = 1500;
        m_t[1] = 1000 + 100 * (m_cur - 1);
        m_mode = 2;
      end else if (m_cur == 16 || m_cur == 17) begin
        for (int i = 0; i < 5; i++) m_t[i] = (m_cur == 16) ? 1000 : 2000;
        m_mode = 2;
      end else begin
        m_err  = (m_cur != 0);
        m_mode = 0;
      end
    end else if (m_mode == 2) begin
      arrived = 1'b1;
      for (int i = 0; i < 5; i++) if (m_w[i] != m_t[i]) arrived = 1'b0;
      if (arrived) begin
        m_mode = 3;
        m_hold = 0;
      end else if (tick) begin
        for (int i = 0; i < 5; i++) begin
          d = m_t[i] - m_w[i];
          if (d > STEP) d = STEP;
          if (d < -STEP) d = -STEP;
          m_w[i] = m_w[i] + d;
        end
      end
    end else if (tick) begin
      m_hold = m_hold + 1;
      if (m_hold == HOLD) begin
        m_done = 1'b1;
        m_mode = 0;
      end
    end
    if (can_push) m_q.push_back(cmd_gesture);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("widths", widths, exp_widths());
      chk("cmd_ready", 80'(cmd_ready), 80'(!reset && (m_q.size() < 4)));
      chk("busy", 80'(busy), 80'((m_q.size() > 0) || (m_mode != 0)));
      chk("done_pulse", 80'(done_pulse), 80'(m_done));
      chk("err_pulse", 80'(err_pulse), 80'(m_err));
    end
  end

  task automatic send(input logic [7:0] g);
    bit acc;
    acc         = 1'b0;
    cmd_valid   = 1'b1;
    cmd_gesture = g;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("send_accepted", 80'(acc), 80'(1));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Follows the index finger of one instance until done_pulse, logging each new width.
  task automatic track_index(input bit use3, output int seq[$], output int gap,
                             output bit others_bad, output bit done_seen);
    logic [79:0] w;
    int last, change_cyc;
    last = 1500; change_cyc = 0; gap = -1; others_bad = 1'b0; done_seen = 1'b0;
    seq.delete();
    for (int c = 0; c < 300 && !done_seen; c++) begin
      @(negedge clk);
      w = use3 ? c3_widths : widths;
      if (int'(w[31:16]) != last) begin
        last = int'(w[31:16]);
        seq.push_back(last);
        change_cyc = c;
      end
      if (w[15:0] != 16'd1500 || w[79:32] != {3{16'd1500}}) others_bad = 1'b1;
      if (use3 ? c3_done : done_pulse) begin
        done_seen = 1'b1;
        gap = c - change_cyc;
      end
    end
  endtask

  initial begin
    int seq[$];
    int gap, acc, dones, errs, changes;
    bit others_bad, done_seen, saw_low, r, hit, moved;
    logic [79:0] lastw;
    reset = 1'b1; cmd_valid = 1'b0; cmd_gesture = 8'h00; c3_valid = 1'b0; c3_gesture = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_widths", widths, {5{16'd1500}});
    chk("rst_ready", 80'(cmd_ready), 80'(1));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_pulses", 80'({done_pulse, err_pulse}), 80'(0));
    @(posedge clk); #1;

    // Gesture 0x01: index steps down to 1000, then a two-tick dwell.
    send(8'h01);
    track_index(1'b0, seq, gap, others_bad, done_seen);
    chk("g01_done_seen", 80'(done_seen), 80'(1));
    chk("g01_steps", 80'(seq.size()), 80'(5));
    for (int i = 0; i < 5; i++)
      chk("g01_index", 80'((i < seq.size()) ? seq[i] : 0), 80'(1400 - 100 * i));
    chk("g01_others", 80'(others_bad), 80'(0));
    chk("g01_hold_gap", 80'(gap), 80'(2 * TICK));
    @(negedge clk);
    chk("g01_busy_after", 80'(busy), 80'(0));
    @(posedge clk); #1;

    // Six back-to-back 0x11 with valid held high.
    pulse_reset();
    cmd_valid = 1'b1; cmd_gesture = 8'h11;
    acc = 0; dones = 0; changes = 0; saw_low = 1'b0; lastw = widths;
    for (int c = 0; c < 800 && dones < 6; c++) begin
      @(negedge clk);
      r = cmd_ready;
      if (!r) saw_low = 1'b1;
      if (done_pulse) dones++;
      if (widths != lastw) begin
        if (dones == 0) changes++;
        lastw = widths;
      end
      @(posedge clk); #1;
      if (r && cmd_valid) begin
        acc++;
        if (acc == 6) cmd_valid = 1'b0;
      end
    end
    chk("b11_accepted", 80'(acc), 80'(6));
    chk("b11_dones", 80'(dones), 80'(6));
    chk("b11_ready_dropped", 80'(saw_low), 80'(1));
    chk("b11_first_ramp_ticks", 80'(changes), 80'(5));
    chk("b11_widths", widths, {5{16'd2000}});
    @(posedge clk); #1;

    // Unknown code, then the no-op code.
    send(8'h20);
    errs = 0; dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (err_pulse) errs++;
      if (done_pulse) dones++;
    end
    chk("g20_err_count", 80'(errs), 80'(1));
    chk("g20_no_done", 80'(dones), 80'(0));
    chk("g20_widths", widths, {5{16'd2000}});
    @(posedge clk); #1;
    send(8'h00);
    errs = 0; dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (err_pulse) errs++;
      if (done_pulse) dones++;
    end
    chk("g00_no_pulses", 80'(errs + dones), 80'(0));
    chk("g00_widths", widths, {5{16'd2000}});
    chk("g00_busy", 80'(busy), 80'(0));
    @(posedge clk); #1;

    // Reset in the middle of a 0x01 ramp with two commands queued.
    pulse_reset();
    send(8'h01);
    send(8'h11);
    send(8'h10);
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      hit = (widths[31:16] == 16'd1200);
    end
    chk("abort_reached_1200", 80'(hit), 80'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_widths", widths, {5{16'd1500}});
    chk("abort_busy", 80'(busy), 80'(0));
    chk("abort_ready", 80'(cmd_ready), 80'(0));
    @(posedge clk); #1 reset = 1'b0;
    dones = 0; moved = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_pulse) dones++;
      if (widths != {5{16'd1500}}) moved = 1'b1;
    end
    chk("abort_no_done", 80'(dones), 80'(0));
    chk("abort_no_motion", 80'(moved), 80'(0));
    chk("abort_idle", 80'(busy), 80'(0));
    @(posedge clk); #1;

    // Larger step: 1500 -> 1200 -> 1000 on the 300 us instance.
    c3_valid = 1'b1; c3_gesture = 8'h01;
    @(negedge clk);
    r = c3_ready;
    @(posedge clk); #1 c3_valid = 1'b0;
    chk("s300_accepted", 80'(r), 80'(1));
    track_index(1'b1, seq, gap, others_bad, done_seen);
    chk("s300_done_seen", 80'(done_seen), 80'(1));
    chk("s300_steps", 80'(seq.size()), 80'(2));
    chk("s300_first", 80'((seq.size() > 0) ? seq[0] : 0), 80'(1200));
    chk("s300_second", 80'((seq.size() > 1) ? seq[1] : 0), 80'(1000));
    chk("s300_hold_gap", 80'(gap), 80'(2 * TICK));
    chk("s300_others", 80'(others_bad), 80'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
